button_conditioner: RTL and testbench

//  Conditions one raw push-button (hour-set, minute-set or test) before it reaches the clock

---
 rtl/button_conditioner.sv | 159 +++++++++++++++
 tb/tb_button_conditioner.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// button_conditioner: 2-FF synchroniser, debounce counter and press-pulse generator for one button.
// Define BUTTON_AUTO_REPEAT_EN to add the hold-to-repeat FSM (DELAY/REPEAT, cnt_rp, held_o).
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES     = 1_000_000,
  parameter int unsigned REPEAT_DELAY_CYCLES = 50_000_000,
  parameter int unsigned REPEAT_RATE_CYCLES  = 20_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic button_i,
  output logic level_o,
  output logic pulse_o,
  output logic held_o
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_TC = DB_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY_CYCLES < 2 || REPEAT_RATE_CYCLES < 2) begin : g_param_check
    $error("button_conditioner: all cycle parameters must be >= 2");
  end

  logic            s1_q, s2_q;
  logic            level_q, level_d;
  logic [DB_W-1:0] cnt_db_q, cnt_db_d;
  logic            rise, fall;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      level_q  <= 1'b0;
      cnt_db_q <= '0;
    end else begin
      s1_q     <= button_i;
      s2_q     <= s1_q;
      level_q  <= level_d;
      cnt_db_q <= cnt_db_d;
    end
  end

  // Any cycle where the synchronised input agrees with level_q restarts the count.
  always_comb begin
    level_d  = level_q;
    cnt_db_d = '0;
    if (s2_q != level_q) begin
      if (cnt_db_q == DB_TC) begin
        level_d = s2_q;
      end else begin
        cnt_db_d = cnt_db_q + 1'b1;
      end
    end
  end

  assign rise    = level_d & ~level_q;
  assign fall    = ~level_d & level_q;
  assign level_o = level_q;

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam int unsigned RP_MAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                                   REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
  localparam int unsigned RP_W = $clog2(RP_MAX);
  localparam logic [RP_W-1:0] DELAY_TC = RP_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RP_W-1:0] RATE_TC  = RP_W'(REPEAT_RATE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  state_t          state_q, state_d;
  logic [RP_W-1:0] cnt_rp_q, cnt_rp_d;
  logic            tick;
  logic            pulse_q, pulse_d;
  logic            held_q, held_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_rp_q <= '0;
      pulse_q  <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_rp_q <= cnt_rp_d;
      pulse_q  <= pulse_d;
      held_q   <= held_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_rp_d = '0;
    tick     = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) state_d = DELAY;
      end
      DELAY: begin
        if (cnt_rp_q == DELAY_TC) begin
          tick    = 1'b1;
          state_d = REPEAT;
        end else begin
          cnt_rp_d = cnt_rp_q + 1'b1;
        end
      end
      REPEAT: begin
        if (cnt_rp_q == RATE_TC) begin
          tick = 1'b1;
        end else begin
          cnt_rp_d = cnt_rp_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (fall) begin
      state_d  = IDLE;
      cnt_rp_d = '0;
    end
  end

  // A release landing on a repeat tick suppresses that tick.
  always_comb begin
    pulse_d = rise | (tick & ~fall);
    held_d  = held_q;
    if (state_q == DELAY && tick) held_d = 1'b1;
    if (fall) held_d = 1'b0;
  end

  assign pulse_o = pulse_q;
  assign held_o  = held_q;
`else
  typedef enum logic {IDLE, PRESSED} state_t;

  state_t state_q, state_d;
  logic   pulse_q, pulse_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && rise) state_d = PRESSED;
    if (fall) state_d = IDLE;
  end

  always_comb begin
    pulse_d = (state_q == IDLE) & rise;
  end

  assign pulse_o = pulse_q;
  assign held_o  = 1'b0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with a pulse-time scoreboard.
// Expectations follow BUTTON_AUTO_REPEAT_EN when the bench is built with it.
module tb_button_conditioner;

  localparam int DB = 8;
  localparam int RD = 20;
  localparam int RR = 5;

  logic clk_i = 1'b0;
  logic rst_i;
  logic button_i;
  logic level_o, pulse_o, held_o;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   exp_q[$];
  logic pulse_prev = 1'b0;

  button_conditioner #(
    .DEBOUNCE_CYCLES    (DB),
    .REPEAT_DELAY_CYCLES(RD),
    .REPEAT_RATE_CYCLES (RR)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .button_i(button_i),
    .level_o (level_o),
    .pulse_o (pulse_o),
    .held_o  (held_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Every observed pulse must match the next scheduled pulse cycle.
  always @(negedge clk_i) begin
    int exp_t;
    if (pulse_o === 1'b1) begin
      exp_t = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      check("pulse_cycle", cyc, exp_t);
      check("pulse_gap", pulse_prev, 0);
    end
    pulse_prev = pulse_o;
  end

  function automatic bit repeat_en();
`ifdef BUTTON_AUTO_REPEAT_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Drive 1 now (at a negedge), release after hold cycles, check level/held every cycle.
  task automatic press(input int hold);
    int c, p, t;
    bit exp_lvl, exp_hld;
    c = cyc;
    button_i = 1'b1;
    p = c + 2 + DB;
    exp_q.push_back(p);
    if (repeat_en()) begin
      t = p + RD;
      while (t < p + hold) begin
        exp_q.push_back(t);
        t += RR;
      end
    end
    for (int i = 1; i <= hold + 2 + DB + 3; i++) begin
      @(negedge clk_i);
      exp_lvl = (cyc >= p) && (cyc < p + hold);
      exp_hld = repeat_en() && (cyc >= p + RD) && (cyc < p + hold);
      check("level", level_o, exp_lvl);
      check("held", held_o, exp_hld);
      if (i == hold) button_i = 1'b0;
    end
    check("pulses_left", exp_q.size(), 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      check("idle_level", level_o, 0);
      check("idle_held", held_o, 0);
    end
  endtask

  initial begin
    int c, p;
    rst_i    = 1'b1;
    button_i = 1'b1;

    // Button held through reset: outputs stay low, press accepted after release.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      check("rst_level", level_o, 0);
      check("rst_pulse", pulse_o, 0);
      check("rst_held", held_o, 0);
    end
    rst_i = 1'b0;
    press(16);
    idle(5);

    // Bounce 1,0,1,0 at 3-cycle spacing, then steady press.
    for (int i = 0; i < 12; i++) begin
      if (i % 3 == 0) button_i = (i % 6 == 0);
      @(negedge clk_i);
      check("bounce_level", level_o, 0);
    end
    press(14);
    idle(5);

    // Long hold: repeats at +20, +25, ... up to the release.
    press(62);
    idle(5);

    // Release coincides with the tick at +45: that tick is suppressed.
    press(45);
    idle(5);

    // FSM back in IDLE: a fresh press behaves normally.
    press(25);
    idle(5);

    // Reset during the repeat phase with the button still held.
    c = cyc;
    button_i = 1'b1;
    p = c + 2 + DB;
    exp_q.push_back(p);
    if (repeat_en()) exp_q.push_back(p + RD);
    while (cyc < p + RD + 2) @(negedge clk_i);
    check("pre_rst_held", held_o, repeat_en());
    check("pre_rst_level", level_o, 1);
    rst_i = 1'b1;
    #1;
    check("async_rst_level", level_o, 0);
    check("async_rst_pulse", pulse_o, 0);
    check("async_rst_held", held_o, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("mid_rst_level", level_o, 0);
      check("mid_rst_pulse", pulse_o, 0);
    end
    rst_i = 1'b0;
    press(14);
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
